// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time-keeping core.
// Holds the FSM state encoding, the BCD digit width, the per-field limits,
// and a helper that converts a small binary constant to two-digit BCD.
package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   localparam int DIGIT_W = 4;

   localparam logic [7:0] CEN_LAST = 8'h99;
   localparam logic [7:0] SEC_LAST = 8'h59;

   // Converts a 0..99 constant to packed BCD {tens,units}.
   function automatic logic [7:0] to_bcd(input int unsigned v);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = 4'((v / 10) % 10);
      units = 4'(v % 10);
      return {tens, units};
   endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit packed-BCD counter that wraps to 00 after reaching LAST.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (value -> 00)
//   clr    - synchronous clear (value -> 00), takes priority over inc
//   inc    - count one step this clock
//   value  - packed BCD {tens,units}
//   carry  - high when this step wraps the counter (inc & value == LAST)
module bcd_pair_counter
   import stopwatch_pkg::*;
#(
   parameter logic [7:0] LAST = 8'h99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] value,
   output logic       carry
);

   logic [DIGIT_W-1:0] lo_q, lo_d;
   logic [DIGIT_W-1:0] hi_q, hi_d;

   assign value = {hi_q, lo_q};
   assign carry = inc & (value == LAST);

   always_comb begin
      lo_d = lo_q;
      hi_d = hi_q;
      if (clr) begin
         lo_d = '0;
         hi_d = '0;
      end else if (inc) begin
         if (value == LAST) begin
            lo_d = '0;
            hi_d = '0;
         end else if (lo_q == 4'd9) begin
            lo_d = '0;
            hi_d = hi_q + 4'd1;
         end else begin
            lo_d = lo_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lo_q <= '0;
         hi_q <= '0;
      end else begin
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch time-keeping core: accumulates MM:SS.CC in packed BCD from the
// centisecond strobe under start/stop/clear control.
// Optional feature macro: LAP_HOLD_EN (lap capture/hold of the displayed time).
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   tick_cen   - one-clk centisecond strobe
//   start_stop - one-clk pulse, toggles run/pause
//   clear      - one-clk pulse, zeroes the time and stops
//   cen_bcd    - centiseconds, packed BCD 00..99
//   sec_bcd    - seconds, packed BCD 00..59
//   min_bcd    - minutes, packed BCD 00..MAX_MIN
//   running    - high while in RUN
//   wrap       - one-clk pulse on MAX_MIN:59.99 -> 00:00.00
//   lap        - (LAP_HOLD_EN) one-clk pulse, toggles the held display in RUN
//   lap_active - (LAP_HOLD_EN) high while outputs show the held time
//
// state    | meaning
// ---------+-------------------------------------------
// ST_IDLE  | time is zero, counter stopped
// ST_RUN   | counting centisecond ticks
// ST_PAUSE | time held (may be nonzero), counter stopped
module stopwatch_bcd_counter
   import stopwatch_pkg::*;
#(
   parameter int MAX_MIN       = 59,
   parameter int START_RUNNING = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_cen,
   input  logic       start_stop,
   input  logic       clear,
   output logic [7:0] cen_bcd,
   output logic [7:0] sec_bcd,
   output logic [7:0] min_bcd,
   output logic       running,
   output logic       wrap
`ifdef LAP_HOLD_EN
   ,
   input  logic       lap,
   output logic       lap_active
`endif
);

   localparam logic [1:0] ST_RESET = (START_RUNNING != 0) ? ST_RUN : ST_IDLE;
   localparam logic [7:0] MIN_LAST = to_bcd(MAX_MIN);

   logic [1:0] state_q, state_d;
   logic       wrap_q;
   logic       cen_inc, sec_inc, min_inc, min_carry;
   logic [7:0] cen_live, sec_live, min_live;

   // Clear wins over a coincident tick, so the counters never see both.
   assign cen_inc = (state_q == ST_RUN) & tick_cen & ~clear;

   bcd_pair_counter #(.LAST(CEN_LAST)) u_cen (
      .clk(clk), .reset(reset), .clr(clear), .inc(cen_inc),
      .value(cen_live), .carry(sec_inc)
   );

   bcd_pair_counter #(.LAST(SEC_LAST)) u_sec (
      .clk(clk), .reset(reset), .clr(clear), .inc(sec_inc),
      .value(sec_live), .carry(min_inc)
   );

   bcd_pair_counter #(.LAST(MIN_LAST)) u_min (
      .clk(clk), .reset(reset), .clr(clear), .inc(min_inc),
      .value(min_live), .carry(min_carry)
   );

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else if (start_stop) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RESET;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wrap_q  <= min_carry;
      end
   end

   assign running = (state_q == ST_RUN);
   assign wrap    = wrap_q;

`ifdef LAP_HOLD_EN
   logic       lap_active_q, lap_active_d;
   logic [7:0] hold_cen_q, hold_sec_q, hold_min_q;
   logic       capture;

   // Capture only when opening a lap; the closing lap just releases the hold.
   assign capture = ~clear & ~start_stop & lap & (state_q == ST_RUN) & ~lap_active_q;

   always_comb begin
      lap_active_d = lap_active_q;
      if (clear || start_stop) begin
         lap_active_d = 1'b0;
      end else if (lap && (state_q == ST_RUN)) begin
         lap_active_d = ~lap_active_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lap_active_q <= 1'b0;
         hold_cen_q   <= 8'h00;
         hold_sec_q   <= 8'h00;
         hold_min_q   <= 8'h00;
      end else begin
         lap_active_q <= lap_active_d;
         if (capture) begin
            hold_cen_q <= cen_live;
            hold_sec_q <= sec_live;
            hold_min_q <= min_live;
         end
      end
   end

   assign lap_active = lap_active_q;
   assign cen_bcd    = lap_active_q ? hold_cen_q : cen_live;
   assign sec_bcd    = lap_active_q ? hold_sec_q : sec_live;
   assign min_bcd    = lap_active_q ? hold_min_q : min_live;
`else
   assign cen_bcd = cen_live;
   assign sec_bcd = sec_live;
   assign min_bcd = min_live;
`endif

endmodule
